// File: rtl/master_port.sv
// Initiator front end for the serial system bus: wins the bus, shifts address and
// write data out LSB-first, and gathers serial read data back into a parallel word.
module master_port #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              in_clk,
  input  logic              reset_n,
  input  logic              par_valid,
  input  logic              par_write,
  input  logic [ADDR_W-1:0] par_addr,
  input  logic [DATA_W-1:0] par_wdata,
  output logic              par_ready,
  output logic [DATA_W-1:0] par_rdata,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              ser_valid,
  output logic              ser_write,
  output logic              ser_addr,
  output logic              ser_wdata,
  input  logic              ser_in_valid_ready,
  input  logic              ser_rdata
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    TX_ADDR,
    TX_DATA,
    WAIT_ACK,
    RX_DATA,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  count;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_sr;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_sr;
  logic [DATA_W-1:0] cap_sr;
  logic [DATA_W-1:0] cap_next;

  // A grant drop in any bus-owning shift phase wins over phase completion.
  always_comb begin
    state_next = state;
    cap_next   = {ser_rdata, cap_sr[DATA_W-1:1]};
    case (state)
      IDLE:     if (par_valid) state_next = REQ;
      REQ:      if (bus_grant) state_next = TX_ADDR;
      TX_ADDR: begin
        if (!bus_grant)              state_next = REQ;
        else if (count == ADDR_LAST) state_next = write_q ? TX_DATA : RX_DATA;
      end
      TX_DATA: begin
        if (!bus_grant)              state_next = REQ;
        else if (count == DATA_LAST) state_next = WAIT_ACK;
      end
      WAIT_ACK: if (ser_in_valid_ready) state_next = DONE;
      RX_DATA: begin
        if (!bus_grant)                                    state_next = REQ;
        else if (ser_in_valid_ready && count == DATA_LAST) state_next = DONE;
      end
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Control registers: phase counter restarts on every state change.
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      par_rdata <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        count <= '0;
      else if (state == TX_ADDR || state == TX_DATA ||
               (state == RX_DATA && ser_in_valid_ready))
        count <= count + CNT_W'(1);
      if (state == RX_DATA && state_next == DONE)
        par_rdata <= cap_next;
    end
  end

  // Shadow and shift registers; REQ reloads the shifters so a regrant resends from bit 0.
  always_ff @(posedge in_clk) begin
    if (state == IDLE && par_valid) begin
      addr_q  <= par_addr;
      data_q  <= par_wdata;
      write_q <= par_write;
    end
    if (state == REQ) begin
      addr_sr <= addr_q;
      data_sr <= data_q;
    end
    if (state == TX_ADDR) addr_sr <= addr_sr >> 1;
    if (state == TX_DATA) data_sr <= data_sr >> 1;
    if (state == RX_DATA && ser_in_valid_ready) cap_sr <= cap_next;
  end

  assign bus_req   = (state == REQ) || (state == TX_ADDR) || (state == TX_DATA) ||
                     (state == WAIT_ACK) || (state == RX_DATA);
  assign ser_write = bus_req & write_q;
  assign ser_valid = (state == TX_ADDR) || (state == TX_DATA);
  assign ser_addr  = (state == TX_ADDR) & addr_sr[0];
  assign ser_wdata = (state == TX_DATA) & data_sr[0];
  assign par_ready = (state == DONE);

endmodule

// File: tb/tb_master_port.sv
// Bench for master_port: acts as requester, arbiter and slave, and checks each
// transfer against word-level expectations and cycle-count rules.
module tb_master_port;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  logic  in_clk = 1'b0;
  logic  reset_n;
  logic  par_valid, par_write;
  addr_t par_addr;
  data_t par_wdata;
  logic  par_ready;
  data_t par_rdata;
  logic  bus_req, bus_grant;
  logic  ser_valid, ser_write, ser_addr, ser_wdata;
  logic  ser_in_valid_ready, ser_rdata;

  int checks = 0;
  int errors = 0;
  data_t last_rdata;

  int    res_ready_cycle, res_ready_cnt, res_first_valid;
  int    res_abits, res_dbits, res_bad_zero, res_bad_write;
  logic  res_req_at_done;
  addr_t res_addr;
  data_t res_wdata, res_rdata;

  always #5 in_clk = ~in_clk;

  master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .in_clk(in_clk), .reset_n(reset_n),
    .par_valid(par_valid), .par_write(par_write), .par_addr(par_addr), .par_wdata(par_wdata),
    .par_ready(par_ready), .par_rdata(par_rdata),
    .bus_req(bus_req), .bus_grant(bus_grant),
    .ser_valid(ser_valid), .ser_write(ser_write), .ser_addr(ser_addr), .ser_wdata(ser_wdata),
    .ser_in_valid_ready(ser_in_valid_ready), .ser_rdata(ser_rdata)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  // Completion cycle from the timing rules: request + grant wait, every bit, then ack or stalls.
  function automatic int exp_ready(bit wr, int g, int drop_at, int ack_dly, int stall_eff);
    int t;
    t = 2 + g + ADDR_W + DATA_W;
    if (drop_at >= 0) t += drop_at + 2;
    if (wr) t += 1 + ack_dly;
    else    t += stall_eff;
    return t;
  endfunction

  // One transfer: cycle 0 presents the request; the loop plays arbiter and slave.
  task automatic run_xfer(input bit wr, input addr_t a, input data_t d, input data_t rw,
                          input int g, input int drop_at, input int ack_dly,
                          input int stall_after, input int stall_len, input bit toggle);
    int c, abit, dbit, rbit, stall_left, wcyc, post, obs_a;
    bit dropped, done;
    c = 0; abit = 0; dbit = 0; rbit = 0; stall_left = 0; wcyc = 0; post = 0;
    dropped = 0; done = 0;
    res_ready_cycle = -1; res_ready_cnt = 0; res_first_valid = -1;
    res_bad_zero = 0; res_bad_write = 0; res_req_at_done = 1'b1;
    res_addr = '0; res_wdata = '0; res_rdata = '0;
    while (!done) begin
      @(negedge in_clk);
      obs_a = -1;
      if (par_ready) begin
        if (res_ready_cnt == 0) begin
          res_ready_cycle = c;
          res_rdata = par_rdata;
          res_req_at_done = bus_req;
        end
        res_ready_cnt++;
      end
      if (ser_write !== (bus_req ? wr : 1'b0)) res_bad_write++;
      if (ser_valid) begin
        if (res_first_valid < 0) res_first_valid = c;
        if (abit < ADDR_W) begin
          res_addr[abit] = ser_addr;
          obs_a = abit;
          abit++;
          if (ser_wdata !== 1'b0) res_bad_zero++;
        end else begin
          if (dbit < DATA_W) res_wdata[dbit] = ser_wdata;
          dbit++;
          if (ser_addr !== 1'b0) res_bad_zero++;
        end
      end else if (ser_addr !== 1'b0 || ser_wdata !== 1'b0) begin
        res_bad_zero++;
      end
      bus_grant = (c >= 1 + g);
      if (!dropped && drop_at >= 0 && obs_a == drop_at) begin
        bus_grant = 1'b0;
        dropped = 1;
        abit = 0;
      end
      if (c == 0) begin
        par_valid = 1'b1; par_write = wr; par_addr = a; par_wdata = d;
      end else if (toggle && res_ready_cnt == 0) begin
        par_valid = 1'($urandom_range(1, 0));
        par_write = 1'($urandom_range(1, 0));
        par_addr  = addr_t'($urandom);
        par_wdata = data_t'($urandom);
      end else begin
        par_valid = 1'b0;
      end
      ser_in_valid_ready = 1'b0;
      ser_rdata = 1'b0;
      if (res_ready_cnt == 0) begin
        if (wr && dbit >= DATA_W && !ser_valid) begin
          ser_in_valid_ready = (wcyc >= ack_dly);
          wcyc++;
        end else if (!wr && abit >= ADDR_W && !ser_valid) begin
          if (stall_left > 0) begin
            ser_rdata = (rbit < DATA_W) ? ~rw[rbit] : 1'b0;
            stall_left--;
          end else if (rbit < DATA_W) begin
            ser_in_valid_ready = 1'b1;
            ser_rdata = rw[rbit];
            if (rbit == stall_after) stall_left = stall_len;
            rbit++;
          end
        end
      end
      if (res_ready_cnt > 0) post++;
      if (post >= 4) done = 1;
      c++;
      if (c > 400) done = 1;
    end
    res_abits = abit;
    res_dbits = dbit;
    par_valid = 1'b0; bus_grant = 1'b0; ser_in_valid_ready = 1'b0; ser_rdata = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({par_ready, bus_req, ser_valid, ser_write, ser_addr, ser_wdata} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl_outputs: got %b expected 000000",
               {par_ready, bus_req, ser_valid, ser_write, ser_addr, ser_wdata});
    end
    checks++;
    if (par_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_rdata: got %h expected 00", par_rdata);
    end
    reset_n = 1'b1;
    @(negedge in_clk);
    par_valid = 1'b1; par_write = 1'b1; par_addr = 12'hFFF; par_wdata = 8'hFF; bus_grant = 1'b1;
    @(negedge in_clk);
    par_valid = 1'b0;
    repeat (3) @(negedge in_clk);
    checks++;
    if (ser_valid !== 1'b1) begin
      errors++; $display("FAIL reset_pre_in_tx_addr: ser_valid got %b expected 1", ser_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({par_ready, bus_req, ser_valid, ser_write, ser_addr, ser_wdata} !== 6'b0 ||
        par_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_xfer: got ctrl=%b rdata=%h expected 000000 / 00",
               {par_ready, bus_req, ser_valid, ser_write, ser_addr, ser_wdata}, par_rdata);
    end
    bus_grant = 1'b0;
    @(negedge in_clk);
    reset_n = 1'b1;
    last_rdata = '0;
    run_xfer(1'b1, 12'h5A3, 8'h96, 8'h00, 0, -1, 0, -1, 0, 1'b0);
    checks++;
    if (res_ready_cycle !== 23 || res_ready_cnt !== 1) begin
      errors++;
      $display("FAIL reset_fresh_write_ready: got cycle %0d count %0d expected 23 / 1",
               res_ready_cycle, res_ready_cnt);
    end
    checks++;
    if (res_addr !== 12'h5A3 || res_wdata !== 8'h96) begin
      errors++;
      $display("FAIL reset_fresh_write_bits: got addr %h data %h expected 5a3 / 96",
               res_addr, res_wdata);
    end
  endtask

  task automatic test_write_basic();
    run_xfer(1'b1, 12'hA5C, 8'h3B, 8'h00, 0, -1, 0, -1, 0, 1'b0);
    checks++;
    if (res_first_valid !== 2) begin
      errors++; $display("FAIL wr_first_addr_cycle: got %0d expected 2", res_first_valid);
    end
    checks++;
    if (res_addr !== 12'hA5C) begin
      errors++; $display("FAIL wr_addr_serial: got %h expected a5c", res_addr);
    end
    checks++;
    if (res_wdata !== 8'h3B || res_dbits !== 8) begin
      errors++;
      $display("FAIL wr_data_serial: got %h (%0d bits) expected 3b (8 bits)", res_wdata, res_dbits);
    end
    checks++;
    if (res_ready_cycle !== 23 || res_ready_cnt !== 1) begin
      errors++;
      $display("FAIL wr_ready: got cycle %0d count %0d expected 23 / 1", res_ready_cycle, res_ready_cnt);
    end
    checks++;
    if (res_req_at_done !== 1'b0) begin
      errors++; $display("FAIL wr_bus_req_at_done: got %b expected 0", res_req_at_done);
    end
    checks++;
    if (res_bad_zero !== 0 || res_bad_write !== 0) begin
      errors++;
      $display("FAIL wr_idle_lines: got %0d stray bits, %0d ser_write errors expected 0 / 0",
               res_bad_zero, res_bad_write);
    end
    checks++;
    if (res_rdata !== last_rdata) begin
      errors++; $display("FAIL wr_rdata_held: got %h expected %h", res_rdata, last_rdata);
    end
  endtask

  task automatic test_read_stall();
    run_xfer(1'b0, 12'h123, 8'h00, 8'hC6, 0, -1, 0, 2, 3, 1'b0);
    checks++;
    if (res_rdata !== 8'hC6) begin
      errors++; $display("FAIL rd_stall_data: got %h expected c6", res_rdata);
    end
    checks++;
    if (res_ready_cycle !== exp_ready(1'b0, 0, -1, 0, 3) || res_ready_cnt !== 1) begin
      errors++;
      $display("FAIL rd_stall_ready: got cycle %0d count %0d expected %0d / 1",
               res_ready_cycle, res_ready_cnt, exp_ready(1'b0, 0, -1, 0, 3));
    end
    checks++;
    if (res_addr !== 12'h123 || res_dbits !== 0 || res_bad_write !== 0) begin
      errors++;
      $display("FAIL rd_stall_addr: got addr %h, %0d data bits, %0d ser_write errors expected 123 / 0 / 0",
               res_addr, res_dbits, res_bad_write);
    end
    last_rdata = 8'hC6;
  endtask

  task automatic test_grant_loss();
    addr_t a;
    data_t d;
    a = addr_t'($urandom);
    d = data_t'($urandom);
    run_xfer(1'b1, a, d, 8'h00, 5, 6, 0, -1, 0, 1'b0);
    checks++;
    if (res_first_valid !== 7) begin
      errors++; $display("FAIL gl_first_addr_cycle: got %0d expected 7", res_first_valid);
    end
    checks++;
    if (res_addr !== a || res_abits !== ADDR_W || res_wdata !== d) begin
      errors++;
      $display("FAIL gl_resend: got addr %h (%0d bits) data %h expected %h (12 bits) / %h",
               res_addr, res_abits, res_wdata, a, d);
    end
    checks++;
    if (res_ready_cycle !== exp_ready(1'b1, 5, 6, 0, 0) || res_ready_cnt !== 1) begin
      errors++;
      $display("FAIL gl_ready: got cycle %0d count %0d expected %0d / 1",
               res_ready_cycle, res_ready_cnt, exp_ready(1'b1, 5, 6, 0, 0));
    end
  endtask

  task automatic test_ack_delay();
    run_xfer(1'b1, 12'h0F0, 8'h5A, 8'h00, 0, -1, 10, -1, 0, 1'b0);
    checks++;
    if (res_ready_cycle !== 33 || res_ready_cnt !== 1) begin
      errors++;
      $display("FAIL ack_delay_ready: got cycle %0d count %0d expected 33 / 1",
               res_ready_cycle, res_ready_cnt);
    end
    checks++;
    if (res_dbits !== DATA_W || res_wdata !== 8'h5A || res_rdata !== last_rdata) begin
      errors++;
      $display("FAIL ack_delay_bits: got %0d bits data %h rdata %h expected 8 / 5a / %h",
               res_dbits, res_wdata, res_rdata, last_rdata);
    end
  endtask

  task automatic test_busy_ignored();
    addr_t a;
    data_t rw;
    a = addr_t'($urandom);
    rw = data_t'($urandom);
    run_xfer(1'b0, a, 8'h00, rw, 2, -1, 0, -1, 0, 1'b1);
    checks++;
    if (res_addr !== a || res_rdata !== rw) begin
      errors++;
      $display("FAIL busy_request_kept: got addr %h rdata %h expected %h / %h", res_addr, res_rdata, a, rw);
    end
    checks++;
    if (res_ready_cnt !== 1 || res_ready_cycle !== exp_ready(1'b0, 2, -1, 0, 0)) begin
      errors++;
      $display("FAIL busy_single_pulse: got count %0d cycle %0d expected 1 / %0d",
               res_ready_cnt, res_ready_cycle, exp_ready(1'b0, 2, -1, 0, 0));
    end
    @(negedge in_clk);
    checks++;
    if (bus_req !== 1'b0) begin
      errors++; $display("FAIL busy_no_second_xfer: bus_req got %b expected 0", bus_req);
    end
    last_rdata = rw;
  endtask

  task automatic test_back_to_back();
    addr_t a;
    data_t d;
    int pulses, p0, p1;
    a = addr_t'($urandom);
    d = data_t'($urandom);
    pulses = 0; p0 = -1; p1 = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge in_clk);
      if (par_ready) begin
        if (pulses == 0) p0 = c;
        else if (pulses == 1) p1 = c;
        pulses++;
      end
      if (c == 24) begin
        checks++;
        if (bus_req !== 1'b0) begin
          errors++; $display("FAIL b2b_idle_gap: bus_req got %b expected 0", bus_req);
        end
      end
      if (c == 26) begin
        checks++;
        if (ser_valid !== 1'b1 || ser_addr !== a[0]) begin
          errors++;
          $display("FAIL b2b_second_start: got valid %b addr bit %b expected 1 / %b",
                   ser_valid, ser_addr, a[0]);
        end
      end
      if (c == 0) begin
        par_valid = 1'b1; par_write = 1'b1; par_addr = a; par_wdata = d;
        bus_grant = 1'b1; ser_in_valid_ready = 1'b1;
      end
      if (c == 25) par_valid = 1'b0;
    end
    checks++;
    if (pulses !== 2 || p0 !== 23 || p1 !== 47) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d pulses at %0d,%0d expected 2 at 23,47", pulses, p0, p1);
    end
    bus_grant = 1'b0; ser_in_valid_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      bit wr;
      addr_t a;
      data_t d, rw;
      int g, drop_at, ack_dly, stall_after, stall_len, er;
      wr = 1'($urandom_range(1, 0));
      a = addr_t'($urandom);
      d = data_t'($urandom);
      rw = data_t'($urandom);
      g = $urandom_range(3, 0);
      drop_at = ($urandom_range(2, 0) == 0) ? $urandom_range(ADDR_W - 1, 0) : -1;
      ack_dly = $urandom_range(4, 0);
      stall_after = ($urandom_range(1, 0) == 1) ? $urandom_range(DATA_W - 2, 0) : -1;
      stall_len = $urandom_range(4, 1);
      run_xfer(wr, a, d, rw, g, drop_at, ack_dly, stall_after, stall_len, 1'b0);
      er = exp_ready(wr, g, drop_at, ack_dly, (stall_after >= 0) ? stall_len : 0);
      checks++;
      if (res_ready_cycle !== er || res_ready_cnt !== 1) begin
        errors++;
        $display("FAIL rand%0d_ready: got cycle %0d count %0d expected %0d / 1",
                 i, res_ready_cycle, res_ready_cnt, er);
      end
      checks++;
      if (res_addr !== a || res_bad_zero !== 0 || res_bad_write !== 0) begin
        errors++;
        $display("FAIL rand%0d_addr: got %h (%0d stray, %0d dir errors) expected %h (0, 0)",
                 i, res_addr, res_bad_zero, res_bad_write, a);
      end
      checks++;
      if (wr && (res_wdata !== d || res_rdata !== last_rdata)) begin
        errors++;
        $display("FAIL rand%0d_write: got data %h rdata %h expected %h / %h",
                 i, res_wdata, res_rdata, d, last_rdata);
      end else if (!wr && res_rdata !== rw) begin
        errors++;
        $display("FAIL rand%0d_read: got %h expected %h", i, res_rdata, rw);
      end
      if (!wr) last_rdata = rw;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    par_valid = 1'b0; par_write = 1'b0; par_addr = '0; par_wdata = '0;
    bus_grant = 1'b0; ser_in_valid_ready = 1'b0; ser_rdata = 1'b0;
    last_rdata = '0;
    repeat (2) @(negedge in_clk);
    test_reset();
    test_write_basic();
    test_read_stall();
    test_grant_loss();
    test_ack_delay();
    test_busy_ignored();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/master_port.md
# master_port

Bus-side front end of an initiator (master) on the serial system bus: accepts one parallel read or write request from the master, arbitrates for the bus, serialises address and write data LSB-first toward the interconnect, and collects serial read data back into a parallel word. It sits directly upstream of the interconnect and the slave-side port, and produces the serial address/data stream they consume.

## Interface
Parameters:
- ADDR_W, 12, address width in bits
- DATA_W, 8, data width in bits

Ports:
- in_clk  in  1  bus clock; single clock domain
- reset_n  in  1  reset, asynchronous, active-low
- par_valid  in  1  master request; sampled only in IDLE
- par_write  in  1  1 = write, 0 = read
- par_addr  in  ADDR_W  request address
- par_wdata  in  DATA_W  write data
- par_ready  out  1  one-cycle completion pulse
- par_rdata  out  DATA_W  read data; valid when par_ready=1 after a read, held otherwise
- bus_req  out  1  arbitration request to the arbiter
- bus_grant  in  1  grant from the arbiter
- ser_valid  out  1  high on every cycle an address or write-data bit is driven
- ser_write  out  1  latched direction, driven while bus_req=1
- ser_addr  out  1  serial address bit
- ser_wdata  out  1  serial write-data bit
- ser_in_valid_ready  in  1  from slave side: write acknowledge / read bit valid
- ser_rdata  in  1  serial read-data bit

## Operation
- States: IDLE, REQ, TX_ADDR, TX_DATA, WAIT_ACK, RX_DATA, DONE.
- IDLE: if par_valid=1, latch par_addr, par_wdata, par_write into shift/shadow registers -> REQ. par_valid in any other state is ignored.
- REQ: bus_req=1. bus_grant=1 -> TX_ADDR, count=0.
- TX_ADDR: ser_valid=1, ser_addr = address bit[count], LSB first; count increments each cycle. After bit ADDR_W-1: write -> TX_DATA, read -> RX_DATA; count cleared.
- TX_DATA: ser_valid=1, ser_wdata = data bit[count], LSB first. After bit DATA_W-1 -> WAIT_ACK.
- WAIT_ACK: wait for ser_in_valid_ready=1 -> DONE. No timeout.
- RX_DATA: on each cycle with ser_in_valid_ready=1, capture ser_rdata as bit[count], LSB first, count++. Cycles with ser_in_valid_ready=0 stall without capture. After bit DATA_W-1 is captured -> DONE.
- DONE: par_ready=1 for exactly one cycle; par_rdata updated from the capture register, on reads only; bus_req deasserts; -> IDLE.
- Grant loss: bus_grant=0 in TX_ADDR, TX_DATA or RX_DATA -> REQ. Latched request retained; transfer restarts from address bit 0; partial read bits discarded. bus_grant is ignored in WAIT_ACK and DONE.
- Counter width $clog2(max(ADDR_W,DATA_W)+1); no wrap inside a phase.
- ser_addr and ser_wdata drive 0 outside their respective phases.

## Timing
- All outputs are registered or decoded from state registers; no combinational path from input to output.
- Reset values (async, immediate): state=IDLE, par_ready=0, par_rdata=0, bus_req=0, ser_valid=0, ser_write=0, ser_addr=0, ser_wdata=0, count=0.
- Reset assertion mid-transfer aborts immediately; no completion pulse is issued.
- Cycle numbering: cycle 0 = IDLE with par_valid sampled. REQ = cycle 1. With grant already high, address bits occupy cycles 2..ADDR_W+1.
- Write, immediate grant and ack: data bits in cycles 14..21, WAIT_ACK in cycle 22, par_ready in cycle 23 (defaults).
- Read, ser_in_valid_ready continuously high from cycle 14: bits captured in cycles 14..21, par_ready in cycle 22.
- Back-to-back: par_valid held high through DONE starts the next request in the following IDLE cycle. Minimum one IDLE cycle between transfers.

## Test plan
- Reset mid-TX_ADDR -> all outputs 0 immediately; a fresh write then completes normally.
- Write addr=0xA5C, data=0x3B, grant and ack immediate -> ser_addr LSB-first 0,0,1,1,1,0,1,0,0,1,0,1 in cycles 2..13; ser_wdata 1,1,0,1,1,1,0,0 in cycles 14..21; par_ready pulse in cycle 23.
- Read addr=0x123, slave returns 0xC6 with valid deasserted for 3 cycles after bit 2 -> par_rdata=0xC6 with a single par_ready pulse; bits not captured during the stall.
- Grant withheld 5 cycles, then dropped during address bit 6 -> returns to REQ; after regrant, the full address is resent from bit 0; the transfer completes correctly.
- Write with ack delayed 10 cycles -> held in WAIT_ACK with ser_valid=0; par_ready asserts one cycle after ack.
- par_valid toggled while busy -> ignored; no second transfer. par_valid held high through DONE -> second transfer begins after one IDLE cycle.
